// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register with Z/V/N flag register, combinational flag
// bypass for branch resolution, and a saturating overflow-event counter.
module ex_flag_stage #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_opcode,
  input  logic [DW-1:0]    in_result,
  input  logic             in_err,
  input  logic             in_wr_en,
  input  logic [3:0]       in_rd,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [DW-1:0]    out_result,
  output logic             out_wr_en,
  output logic [3:0]       out_rd,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             byp_z,
  output logic             byp_v,
  output logic             byp_n,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_XOR = 4'h2,
    OP_SLL = 4'h4,
    OP_SRA = 4'h5,
    OP_ROR = 4'h6
  } opcode_e;

  logic             acc;
  logic             arith_op;

  logic             valid_q,  valid_d;
  logic [DW-1:0]    result_q, result_d;
  logic             wr_en_q,  wr_en_d;
  logic [3:0]       rd_q,     rd_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             n_q, n_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  assign acc      = in_valid & ~stall & ~flush;
  assign arith_op = (in_opcode == OP_ADD) || (in_opcode == OP_SUB);

  // Pipeline register next state: stall holds everything, otherwise load or bubble
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    wr_en_d  = wr_en_q;
    rd_d     = rd_q;
    if (!stall) begin
      valid_d = acc;
      wr_en_d = acc & in_wr_en;
      if (acc) begin
        result_d = in_result;
        rd_d     = in_rd;
      end
    end
  end

  // Flag next state by opcode; also serves as the bypass value (independent of rst)
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    n_d = n_q;
    if (acc) begin
      case (in_opcode)
        OP_ADD, OP_SUB: begin
          z_d = (in_result == '0);
          v_d = in_err;
          n_d = in_result[DW-1];
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
          z_d = (in_result == '0);
        end
        default: ;
      endcase
    end
  end

  // Overflow-event counter: committed ADD/SUB overflows, saturating at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (acc && in_err && arith_op && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset taking priority over stall/flush
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      wr_en_q  <= 1'b0;
      rd_q     <= '0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      wr_en_q  <= wr_en_d;
      rd_q     <= rd_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_wr_en  = wr_en_q;
  assign out_rd     = rd_q;
  assign flag_z     = z_q;
  assign flag_v     = v_q;
  assign flag_n     = n_q;
  assign byp_z      = z_d;
  assign byp_v      = v_d;
  assign byp_n      = n_d;
  assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Self-checking bench for ex_flag_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_ex_flag_stage;

  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [3:0]       in_opcode;
  logic [DW-1:0]    in_result;
  logic             in_err;
  logic             in_wr_en;
  logic [3:0]       in_rd;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [DW-1:0]    out_result;
  logic             out_wr_en;
  logic [3:0]       out_rd;
  logic             flag_z, flag_v, flag_n;
  logic             byp_z, byp_v, byp_n;
  logic [CNT_W-1:0] ovf_count;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model state
  logic          m_valid, m_wr, m_z, m_v, m_n;
  logic [3:0]    m_rd;
  logic [DW-1:0] m_res;
  int            m_cnt;

  ex_flag_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_result(in_result), .in_err(in_err), .in_wr_en(in_wr_en), .in_rd(in_rd),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_result(out_result),
    .out_wr_en(out_wr_en), .out_rd(out_rd), .flag_z(flag_z), .flag_v(flag_v),
    .flag_n(flag_n), .byp_z(byp_z), .byp_v(byp_v), .byp_n(byp_n),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  // Flags the architecture should hold after this cycle, ignoring reset.
  function automatic logic [2:0] pred_flags();
    logic accepted;
    accepted = in_valid && !stall && !flush;
    if (accepted && (in_opcode == 4'h0 || in_opcode == 4'h1))
      return {in_result == 16'h0000, in_err, in_result[DW-1]};
    if (accepted && (in_opcode == 4'h2 || in_opcode == 4'h4 ||
                     in_opcode == 4'h5 || in_opcode == 4'h6))
      return {in_result == 16'h0000, m_v, m_n};
    return {m_z, m_v, m_n};
  endfunction

  // Advance model by one clock using current inputs, then step the clock.
  task automatic cycle();
    logic [2:0] f;
    f = pred_flags();
    if (rst) begin
      m_valid = 0; m_wr = 0; m_rd = 0; m_res = 0;
      m_z = 0; m_v = 0; m_n = 0; m_cnt = 0;
    end else if (!stall) begin
      if (in_valid && !flush) begin
        m_valid = 1; m_wr = in_wr_en; m_rd = in_rd; m_res = in_result;
        {m_z, m_v, m_n} = f;
        if (in_err && in_opcode <= 4'h1 && m_cnt < 255) m_cnt = m_cnt + 1;
      end else begin
        m_valid = 0; m_wr = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic err, input logic st, input logic fl);
    in_valid = v; in_opcode = op; in_result = res; in_err = err;
    stall = st; flush = fl;
  endtask

  task automatic test_reset();
    rst = 1; in_wr_en = 1; in_rd = 4'h9;
    drive(1, 4'h0, 16'h0000, 0, 0, 0);
    cycle();
    n_cmp++;
    if ({out_valid, out_wr_en, out_rd, out_result, flag_z, flag_v, flag_n, ovf_count} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b wr=%b rd=%h res=%h zvn=%b%b%b cnt=%h, want all 0",
               out_valid, out_wr_en, out_rd, out_result, flag_z, flag_v, flag_n, ovf_count);
    end
    // bypass is not a function of rst: accepted ADD of zero predicts Z=1
    #2;
    n_cmp++;
    if ({byp_z, byp_v, byp_n} !== 3'b100) begin
      n_err++; $display("FAIL reset_bypass: got %b%b%b want 100", byp_z, byp_v, byp_n);
    end
    cycle();
    n_cmp++;
    if ({out_valid, flag_z} !== 2'b00) begin
      n_err++; $display("FAIL reset_discard: got valid=%b z=%b want 0 0", out_valid, flag_z);
    end
    rst = 0;
  endtask

  task automatic test_add_overflow();
    in_wr_en = 1; in_rd = 4'h3;
    drive(1, 4'h0, 16'h7FFF, 1, 0, 0);
    #2;
    n_cmp++;
    if ({byp_z, byp_v, byp_n} !== 3'b010) begin
      n_err++; $display("FAIL add_ovf_bypass: got %b%b%b want 010", byp_z, byp_v, byp_n);
    end
    cycle();
    n_cmp++;
    if ({out_valid, out_wr_en, out_rd, out_result, flag_z, flag_v, flag_n, ovf_count} !==
        {1'b1, 1'b1, 4'h3, 16'h7FFF, 3'b010, 8'd1}) begin
      n_err++;
      $display("FAIL add_ovf: got v=%b wr=%b rd=%h res=%h zvn=%b%b%b cnt=%0d want 1 1 3 7fff 010 1",
               out_valid, out_wr_en, out_rd, out_result, flag_z, flag_v, flag_n, ovf_count);
    end
  endtask

  task automatic test_sub_neg();
    in_rd = 4'h5;
    drive(1, 4'h1, 16'h8000, 1, 0, 0);
    cycle();
    n_cmp++;
    if ({flag_z, flag_v, flag_n, ovf_count} !== {3'b011, 8'd2}) begin
      n_err++; $display("FAIL sub_neg: got zvn=%b%b%b cnt=%0d want 011 2",
                        flag_z, flag_v, flag_n, ovf_count);
    end
    drive(1, 4'h2, 16'h0000, 0, 0, 0);
    #2;
    n_cmp++;
    if ({byp_z, byp_v, byp_n} !== 3'b111) begin
      n_err++; $display("FAIL xor_bypass: got %b%b%b want 111", byp_z, byp_v, byp_n);
    end
    cycle();
    n_cmp++;
    if ({flag_z, flag_v, flag_n, ovf_count, out_result} !== {3'b111, 8'd2, 16'h0000}) begin
      n_err++; $display("FAIL xor_zero: got zvn=%b%b%b cnt=%0d res=%h want 111 2 0000",
                        flag_z, flag_v, flag_n, ovf_count, out_result);
    end
  endtask

  task automatic test_stall_flush();
    in_rd = 4'hA;
    for (int i = 0; i < 2; i++) begin
      // second stalled cycle also asserts flush: stall must win
      drive(1, 4'h0, 16'h0005, 0, 1, (i == 1));
      #2;
      n_cmp++;
      if ({byp_z, byp_v, byp_n} !== 3'b111) begin
        n_err++; $display("FAIL stall_bypass[%0d]: got %b%b%b want 111", i, byp_z, byp_v, byp_n);
      end
      cycle();
      n_cmp++;
      if ({out_valid, out_wr_en, out_rd, out_result, flag_z, flag_v, flag_n, ovf_count} !==
          {1'b1, 1'b1, 4'h5, 16'h0000, 3'b111, 8'd2}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b wr=%b rd=%h res=%h zvn=%b%b%b cnt=%0d", i,
                 out_valid, out_wr_en, out_rd, out_result, flag_z, flag_v, flag_n, ovf_count);
      end
    end
    drive(1, 4'h0, 16'h0005, 1, 0, 1);
    cycle();
    n_cmp++;
    if ({out_valid, out_wr_en, out_rd, out_result, flag_z, flag_v, flag_n, ovf_count} !==
        {1'b0, 1'b0, 4'h5, 16'h0000, 3'b111, 8'd2}) begin
      n_err++;
      $display("FAIL flush_bubble: got v=%b wr=%b rd=%h res=%h zvn=%b%b%b cnt=%0d want 0 0 5 0000 111 2",
               out_valid, out_wr_en, out_rd, out_result, flag_z, flag_v, flag_n, ovf_count);
    end
  endtask

  task automatic test_nonflag();
    in_rd = 4'h7;
    drive(1, 4'h7, 16'h8000, 1, 0, 0);
    #2;
    n_cmp++;
    if ({byp_z, byp_v, byp_n} !== {flag_z, flag_v, flag_n} || {byp_z, byp_v, byp_n} !== 3'b111) begin
      n_err++; $display("FAIL nonflag_bypass: got %b%b%b want 111", byp_z, byp_v, byp_n);
    end
    cycle();
    n_cmp++;
    if ({out_valid, out_result, flag_z, flag_v, flag_n, ovf_count} !==
        {1'b1, 16'h8000, 3'b111, 8'd2}) begin
      n_err++; $display("FAIL nonflag: got v=%b res=%h zvn=%b%b%b cnt=%0d want 1 8000 111 2",
                        out_valid, out_result, flag_z, flag_v, flag_n, ovf_count);
    end
  endtask

  task automatic test_counter_sat();
    rst = 1; drive(0, 4'h0, 16'h0000, 0, 0, 0);
    cycle();
    rst = 0;
    for (int i = 1; i <= 300; i++) begin
      drive(1, (i % 2 == 0) ? 4'h0 : 4'h0, 16'h7FFF, 1, 0, 0);
      cycle();
      if (i == 254 || i == 255 || i == 300) begin
        n_cmp++;
        if (ovf_count !== ((i >= 255) ? 8'hFF : 8'(i))) begin
          n_err++; $display("FAIL counter_sat[%0d]: got %h want %h", i, ovf_count,
                            (i >= 255) ? 8'hFF : 8'(i));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 4))
        0: r = 16'h0000;
        1: r = 16'h7FFF;
        2: r = 16'h8000;
        default: r = 16'($urandom);
      endcase
      in_wr_en = 1'($urandom);
      in_rd    = 4'($urandom);
      drive(($urandom_range(0, 4) != 0), 4'($urandom_range(0, 8)), r, 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      #2;
      n_cmp++;
      if ({byp_z, byp_v, byp_n} !== pred_flags()) begin
        n_err++; $display("FAIL rand_bypass[%0d]: got %b%b%b want %b", i, byp_z, byp_v, byp_n,
                          pred_flags());
      end
      cycle();
      n_cmp++;
      if ({out_valid, out_wr_en, out_rd, out_result, flag_z, flag_v, flag_n, ovf_count} !==
          {m_valid, m_wr, m_rd, m_res, m_z, m_v, m_n, 8'(m_cnt)}) begin
        n_err++;
        $display("FAIL rand_state[%0d]: got v=%b wr=%b rd=%h res=%h zvn=%b%b%b cnt=%0d want v=%b wr=%b rd=%h res=%h zvn=%b%b%b cnt=%0d",
                 i, out_valid, out_wr_en, out_rd, out_result, flag_z, flag_v, flag_n, ovf_count,
                 m_valid, m_wr, m_rd, m_res, m_z, m_v, m_n, m_cnt);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 0; in_wr_en = 0; in_rd = 0;
    drive(0, 4'h0, 16'h0000, 0, 0, 0);
    m_valid = 0; m_wr = 0; m_rd = 0; m_res = 0; m_z = 0; m_v = 0; m_n = 0; m_cnt = 0;
    #1;
    test_reset();
    test_add_overflow();
    test_sub_neg();
    test_stall_flush();
    test_nonflag();
    test_counter_sat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
